// File: rtl/ysyx_24120013_ctrl_pkg.sv
// ysyx_24120013_ctrl_pkg: shared types for the multi-cycle core sequencer.
// Revision: 1.0
`default_nettype none

package ysyx_24120013_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef logic [1:0] halt_code_t;

  localparam halt_code_t HALT_NONE      = 2'd0;
  localparam halt_code_t HALT_EBREAK    = 2'd1;
  localparam halt_code_t HALT_FETCH_ERR = 2'd2;
  localparam halt_code_t HALT_FETCH_TMO = 2'd3;

endpackage

`default_nettype wire

// File: rtl/ysyx_24120013_fetch_wdog.sv
// ysyx_24120013_fetch_wdog: clearable fetch-wait counter; expired flags the last allowed idle cycle.
// Revision: 1.0
`default_nettype none

module ysyx_24120013_fetch_wdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_tmo_on
      localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      logic [CW-1:0] cnt;

      always_ff @(posedge clk) begin
        if (rst || clr) begin
          cnt <= '0;
        end else if (en) begin
          cnt <= cnt + CW'(1);
        end
      end

      assign expired = en && (cnt == CW'(TIMEOUT_CYCLES - 1));
    end else begin : g_tmo_off
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clk, rst, clr, en};
      assign expired = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/ysyx_24120013_core_ctrl.sv
// ysyx_24120013_core_ctrl: FETCH/DECODE/EXEC/WB sequencer with halt detection and cycle/instret counters.
// Revision: 1.0
`default_nettype none

module ysyx_24120013_core_ctrl
  import ysyx_24120013_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ifu_req,
  input  logic                 ifu_rvalid,
  input  logic                 ifu_err,
  output logic                 idu_latch,
  input  logic                 halt_req,
  output logic                 exu_start,
  input  logic                 exu_done,
  output logic                 rf_wen_gate,
  output logic                 pc_update,
  output logic                 halted,
  output logic [1:0]           halt_code,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instret
);

  state_t     state, state_next;
  halt_code_t code_q, code_next;
  logic       exec_first;
  logic       wdog_clr, wdog_en, wdog_expired;

  // Holding the counter clear outside FETCH guarantees it starts at zero on every entry.
  assign wdog_clr = (state != ST_FETCH);
  assign wdog_en  = (state == ST_FETCH) && !ifu_rvalid && !ifu_err;

  ysyx_24120013_fetch_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fetch_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wdog_clr),
    .en     (wdog_en),
    .expired(wdog_expired)
  );

  always_comb begin
    state_next = state;
    code_next  = code_q;
    case (state)
      ST_IDLE:   state_next = ST_FETCH;
      ST_FETCH: begin
        if (ifu_err) begin
          state_next = ST_HALT;
          code_next  = HALT_FETCH_ERR;
        end else if (ifu_rvalid) begin
          state_next = ST_DECODE;
        end else if (wdog_expired) begin
          state_next = ST_HALT;
          code_next  = HALT_FETCH_TMO;
        end
      end
      ST_DECODE: begin
        if (halt_req) begin
          state_next = ST_HALT;
          code_next  = HALT_EBREAK;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC:   if (exu_done) state_next = ST_WB;
      ST_WB:     state_next = ST_FETCH;
      ST_HALT:   state_next = ST_HALT;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      code_q     <= HALT_NONE;
      exec_first <= 1'b0;
      cycle_cnt  <= '0;
      instret    <= '0;
    end else begin
      state      <= state_next;
      code_q     <= code_next;
      // Registered marker so exu_start stays a Moore pulse on the first EXEC cycle only.
      exec_first <= (state == ST_DECODE) && (state_next == ST_EXEC);
      if (state inside {ST_FETCH, ST_DECODE, ST_EXEC, ST_WB}) begin
        cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
      end
      // An ebreak retires at the DECODE->HALT transition, without a WB cycle.
      if ((state == ST_WB) || ((state == ST_DECODE) && halt_req)) begin
        instret <= instret + CNT_WIDTH'(1);
      end
    end
  end

  assign ifu_req     = (state == ST_FETCH);
  assign idu_latch   = (state == ST_DECODE);
  assign exu_start   = (state == ST_EXEC) && exec_first;
  assign rf_wen_gate = (state == ST_WB);
  assign pc_update   = (state == ST_WB);
  assign halted      = (state == ST_HALT);
  assign halt_code   = code_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24120013_core_ctrl.sv
// tb_ysyx_24120013_core_ctrl: randomized instruction stream with a cycle-budget model and a
// scoreboard monitor that checks every retirement and halt.
`default_nettype none

module tb_ysyx_24120013_core_ctrl;

  localparam int TMO = 8;

  logic        clk, rst;
  logic        ifu_req, ifu_rvalid, ifu_err, idu_latch, halt_req;
  logic        exu_start, exu_done, rf_wen_gate, pc_update, halted;
  logic [1:0]  halt_code;
  logic [31:0] cycle_cnt, instret;

  ysyx_24120013_core_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .ifu_req(ifu_req), .ifu_rvalid(ifu_rvalid), .ifu_err(ifu_err),
    .idu_latch(idu_latch), .halt_req(halt_req), .exu_start(exu_start), .exu_done(exu_done),
    .rf_wen_gate(rf_wen_gate), .pc_update(pc_update), .halted(halted), .halt_code(halt_code),
    .cycle_cnt(cycle_cnt), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 retire through WB, 1 ebreak, 2 fetch error, 3 fetch timeout
  typedef struct {
    int kind;
    int fetch_len;
    int exec_len;
    int instret;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- stimulus and reference model ----------------
  int n_ret, base;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cyc(input logic rv, input logic er, input logic hr, input logic dn);
    ifu_rvalid = rv; ifu_err = er; halt_req = hr; exu_done = dn;
    @(posedge clk); #1;
  endtask

  task automatic release_check();
    rst = 1'b0;
    n_ret = 0;
    base  = 0;
    chk("rst_ifu_req", ifu_req, 0);
    chk("rst_idu_latch", idu_latch, 0);
    chk("rst_exu_start", exu_start, 0);
    chk("rst_rf_wen", rf_wen_gate, 0);
    chk("rst_pc_update", pc_update, 0);
    chk("rst_halted", halted, 0);
    chk("rst_halt_code", halt_code, 0);
    chk("rst_cycle_cnt", cycle_cnt, 0);
    chk("rst_instret", instret, 0);
    cyc(rb(), rb(), rb(), rb());
    chk("first_ifu_req", ifu_req, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(rb(), rb(), rb(), rb());
    cyc(rb(), rb(), rb(), rb());
    release_check();
  endtask

  // Entered in the first FETCH cycle of the instruction.
  task automatic instr(input int kind, input int w, input int e);
    exp_t x;
    x.kind      = kind;
    x.fetch_len = (kind == 3) ? TMO : w + 1;
    x.exec_len  = e + 1;
    case (kind)
      0:       begin x.instret = n_ret;     x.cyc = base + w + e + 3; end
      1:       begin x.instret = n_ret + 1; x.cyc = base + w + 2;     end
      2:       begin x.instret = n_ret;     x.cyc = base + w + 1;     end
      default: begin x.instret = n_ret;     x.cyc = base + TMO;       end
    endcase
    sbq.push_back(x);
    if (kind == 3) begin
      repeat (TMO) cyc(1'b0, 1'b0, rb(), rb());
    end else begin
      repeat (w) cyc(1'b0, 1'b0, rb(), rb());
      if (kind == 2) begin
        cyc((w % 2) == 0, 1'b1, rb(), rb());
      end else begin
        cyc(1'b1, 1'b0, rb(), rb());
        cyc(rb(), rb(), kind == 1, rb());
        if (kind == 0) begin
          repeat (e) cyc(rb(), rb(), rb(), 1'b0);
          cyc(rb(), rb(), rb(), 1'b1);
          cyc(rb(), rb(), rb(), rb());
          n_ret++;
          base += w + e + 4;
        end
      end
    end
  endtask

  task automatic rst_in_exec(input int w, input int j);
    repeat (w) cyc(1'b0, 1'b0, rb(), rb());
    cyc(1'b1, 1'b0, rb(), rb());
    cyc(rb(), rb(), 1'b0, rb());
    repeat (j) cyc(rb(), rb(), rb(), 1'b0);
    rst = 1'b1;
    cyc(rb(), rb(), rb(), 1'b1);
    release_check();
  endtask

  task automatic hold_and_close(input int n);
    repeat (n) cyc(rb(), rb(), rb(), rb());
    chk("sb_drained", sbq.size(), 0);
  endtask

  initial begin
    rst = 1'b1; ifu_rvalid = 1'b0; ifu_err = 1'b0; halt_req = 1'b0; exu_done = 1'b0;
    // Back-to-back single-cycle instructions, then ebreak on the 11th.
    do_reset();
    repeat (10) instr(0, 0, 0);
    instr(1, 0, 0);
    hold_and_close(100);
    // Memory wait 3, EXU latency 2; ebreak on the 5th instruction.
    do_reset();
    repeat (4) instr(0, 3, 1);
    instr(1, 3, 0);
    hold_and_close(20);
    // Fetch error together with rvalid.
    do_reset();
    instr(0, 1, 0);
    instr(2, 0, 0);
    hold_and_close(20);
    // Longest legal wait, then timeout.
    do_reset();
    instr(0, TMO - 1, 2);
    instr(3, 0, 0);
    hold_and_close(20);
    // Reset on the first EXEC cycle with exu_done high.
    do_reset();
    instr(0, 0, 0);
    rst_in_exec(0, 0);
    instr(0, 2, 1);
    instr(1, 0, 0);
    hold_and_close(10);
    for (int ep = 0; ep < 16; ep++) begin
      int n, ending;
      do_reset();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) instr(0, $urandom_range(0, TMO - 1), $urandom_range(0, 3));
      ending = $urandom_range(1, 4);
      if (ending == 4) begin
        rst_in_exec($urandom_range(0, 3), $urandom_range(0, 2));
        instr(0, $urandom_range(0, TMO - 1), $urandom_range(0, 3));
        instr(1, $urandom_range(0, TMO - 1), 0);
      end else begin
        instr(ending, $urandom_range(0, TMO - 1), 0);
      end
      hold_and_close(15);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- scoreboard monitor ----------------
  exp_t mx;
  int   f_run, x_run, n_start, n_dec, h_code, h_ret, h_cyc;
  bit   in_exec, halt_seen;

  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      f_run = 0; x_run = 0; n_start = 0; n_dec = 0;
      in_exec = 1'b0; halt_seen = 1'b0;
    end else if (halted) begin
      if (!halt_seen) begin
        halt_seen = 1'b1;
        if (sbq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL halt_pop: halted with nothing expected (t=%0t)", $time);
          h_code = 0; h_ret = 0; h_cyc = 0;
        end else begin
          mx = sbq.pop_front();
          chk("halt_code", halt_code, mx.kind);
          chk("halt_instret", instret, mx.instret);
          chk("halt_cycle_cnt", cycle_cnt, mx.cyc);
          chk("halt_fetch_len", f_run, mx.fetch_len);
          chk("halt_decodes", n_dec, (mx.kind == 1) ? 1 : 0);
          chk("halt_exu_starts", n_start, 0);
          h_code = mx.kind; h_ret = mx.instret; h_cyc = mx.cyc;
        end
      end else begin
        chk("hold_code", halt_code, h_code);
        chk("hold_instret", instret, h_ret);
        chk("hold_cycle_cnt", cycle_cnt, h_cyc);
        chk("hold_quiet", {ifu_req, idu_latch, exu_start, pc_update, rf_wen_gate}, 0);
      end
    end else begin
      if (ifu_req) f_run++;
      if (idu_latch) n_dec++;
      if (exu_start) begin
        n_start++;
        in_exec = 1'b1;
      end
      if (pc_update) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL wb_pop: retirement with nothing expected (t=%0t)", $time);
        end else begin
          mx = sbq.pop_front();
          chk("wb_kind", 0, mx.kind);
          chk("wb_fetch_len", f_run, mx.fetch_len);
          chk("wb_exec_len", x_run, mx.exec_len);
          chk("wb_decodes", n_dec, 1);
          chk("wb_exu_starts", n_start, 1);
          chk("wb_rf_wen", rf_wen_gate, 1);
          chk("wb_instret", instret, mx.instret);
          chk("wb_cycle_cnt", cycle_cnt, mx.cyc);
        end
        f_run = 0; x_run = 0; n_start = 0; n_dec = 0; in_exec = 1'b0;
      end else if (in_exec) begin
        x_run++;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/ysyx_24120013_core_ctrl.md
# ysyx_24120013_core_ctrl

Multi-cycle sequencer for the ysyx_24120013 core. It replaces free-running single-cycle stepping with an explicit FETCH → DECODE → EXEC → WB loop. It handshakes with instruction memory and gates the IFU/IDU latches, the EXU start, the register-file write enable and the PC update. It also owns halt detection (ebreak, fetch error, fetch timeout) and the cycle/instret counters consumed by the simulation environment.

## Interface
- TIMEOUT_CYCLES, 255: max FETCH cycles without `ifu_rvalid` before timeout halt; 0 disables the timeout.
- CNT_WIDTH, 32: width of `cycle_cnt` and `instret`.

- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ifu_req  out  1  instruction fetch request; high in every FETCH cycle.
- ifu_rvalid  in  1  fetched instruction valid this cycle.
- ifu_err  in  1  fetch access fault this cycle.
- idu_latch  out  1  one-cycle pulse in DECODE; IDU captures the instruction and regfile reads.
- halt_req  in  1  decoder flags ebreak; sampled only in DECODE.
- exu_start  out  1  one-cycle pulse on the first EXEC cycle.
- exu_done  in  1  EXU result ready; sampled in every EXEC cycle, including the first.
- rf_wen_gate  out  1  high only in WB; ANDed with the EXU write enable.
- pc_update  out  1  high only in WB; PC loads next/jump value.
- halted  out  1  sticky; high in HALT.
- halt_code  out  2  0 none, 1 ebreak, 2 fetch error, 3 fetch timeout.
- cycle_cnt  out  CNT_WIDTH  cycles since reset, excluding IDLE and HALT.
- instret  out  CNT_WIDTH  retired instructions.

## Operation
- States and transitions:
  - IDLE → FETCH, unconditionally after one cycle.
  - FETCH → DECODE on `ifu_rvalid`.
  - FETCH → HALT (code 2) on `ifu_err`.
  - FETCH → HALT (code 3) on timeout.
  - DECODE → HALT (code 1) on `halt_req`; otherwise DECODE → EXEC.
  - EXEC → WB on `exu_done`.
  - WB → FETCH.
  - HALT is absorbing; only `rst` exits it.
- Priority in FETCH: `ifu_err` > `ifu_rvalid` > timeout.
- Timeout counter:
  - Cleared on FETCH entry.
  - Increments each FETCH cycle without `ifu_rvalid`/`ifu_err`.
  - Timeout fires when the counter equals TIMEOUT_CYCLES−1 and neither input is high.
- ebreak retires: `instret` increments on the DECODE→HALT(1) transition. There is no WB pulse and no `pc_update`, so the PC stays at the ebreak address.
- `instret` increments once per WB cycle.
- `cycle_cnt` increments in FETCH/DECODE/EXEC/WB.
- Both counters wrap modulo 2^CNT_WIDTH.
- Error and timeout halts do not increment `instret`.
- `halt_code` is written once on HALT entry and is stable until reset.
- All outputs are Moore outputs decoded from the registered state; there is no combinational path from inputs to outputs.

## Timing
- Reset values: state IDLE; all outputs 0; counters 0; timeout counter 0.
- `rst` asserted in any state: IDLE on the next edge.
  - All pulses drop and in-flight fetch/EXU work is abandoned.
  - `ifu_rvalid`/`exu_done` arriving in IDLE are ignored.
- Minimum instruction latency is 4 cycles (FETCH, DECODE, EXEC, WB) when `ifu_rvalid` and `exu_done` are high on their first sampled cycle.
- Each extra memory wait cycle adds 1; each extra EXU cycle adds 1.
- `exu_start` is high for exactly one cycle per instruction, even when EXEC lasts several cycles.
- `ifu_req` is held continuously across fetch wait cycles and drops the cycle after `ifu_rvalid` is accepted.
- First `ifu_req` appears in cycle 1 after reset deassertion (cycle 0 = IDLE).

## Structure
- Package ysyx_24120013_ctrl_pkg holds:
  - the state enum (IDLE, FETCH, DECODE, EXEC, WB, HALT);
  - halt code constants (HALT_NONE, HALT_EBREAK, HALT_FETCH_ERR, HALT_FETCH_TMO);
  - the 2-bit halt code type.
- One sub-module: ysyx_24120013_fetch_wdog. It is the clearable timeout counter with a TIMEOUT_CYCLES parameter, `clr`/`en` inputs and an `expired` output. When TIMEOUT_CYCLES is 0, `expired` is tied to 0.
- The top-level core instantiates core_ctrl and gates the PC, IFU, IDU, register file and EXU with its outputs.

## Test plan
- Back-to-back instructions, `ifu_rvalid` and `exu_done` always high → `ifu_req` period of 4 cycles; `instret`=10 and `cycle_cnt`=40 after 40 active cycles; `rf_wen_gate` high 10 cycles total.
- Memory wait of 3 cycles, EXU latency 2 → 8 cycles per instruction; `exu_start` a single pulse; `ifu_req` high 4 consecutive cycles.
- `halt_req` in DECODE of the 5th instruction → `halted`=1, `halt_code`=1, `instret`=5, no `pc_update` in that instruction, and state held for 100 further cycles.
- `ifu_err` and `ifu_rvalid` high together in FETCH → HALT with code 2; `instret` unchanged; `cycle_cnt` frozen.
- TIMEOUT_CYCLES=8, `ifu_rvalid` never asserted → HALT code 3 entered after exactly 8 FETCH cycles; with TIMEOUT_CYCLES=0, still in FETCH after 1000 cycles.
- `rst` pulsed during EXEC with `exu_done` arriving the same cycle → next state IDLE; all outputs and counters 0; first `ifu_req` exactly one cycle after `rst` drops.
